mat_mem_arbiter: RTL and testbench

MAT_MEM_ARBITER -- requirements
Module: mat_mem_arbiter

---
 rtl/mat_mem_arbiter.sv | 60 ++++++
 tb/tb_mat_mem_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mat_mem_arbiter.sv
// mat_mem_arbiter: rotating-priority arbiter sharing one data memory port among NUM_REQ requesters, with burst lock.
module mat_mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic                           busy
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr, gnt, idx;
  logic found, acc;
  logic [NUM_REQ-1:0] rsp_q;
  // first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  assign acc       = found & ~reset;
  assign req_ready = acc ? (NUM_REQ'(1) << gnt) : '0;
  assign mem_en    = acc;
  assign mem_we    = acc & req_we[gnt];
  assign mem_addr  = acc ? req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_wdata = acc ? req_wdata[gnt*DATA_WIDTH +: DATA_WIDTH] : '0;
  // a response landing in a reset cycle is dropped
  assign rsp_valid = reset ? '0 : rsp_q;
  assign rsp_rdata = |rsp_valid ? mem_rdata : '0;
  assign busy      = ~reset & (|req_valid | |rsp_q);
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr   <= '0;
      rsp_q <= '0;
    end else begin
      rsp_q <= (acc & ~req_we[gnt]) ? req_ready : '0;
      if (acc) ptr <= req_lock[gnt] ? gnt : (gnt == PW'(NUM_REQ - 1) ? '0 : gnt + 1'b1);
    end
  end
endmodule

// File: tb/tb_mat_mem_arbiter.sv
// tb_mat_mem_arbiter: directed scenarios plus random traffic checked against a behavioural arbiter/memory model.
module tb_mat_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MS = 1 << AW;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_en, mem_we, busy;
  logic init_mem;
  logic [DW-1:0] dmem [MS];
  logic [DW-1:0] shadow [MS];
  int checks = 0;
  int errors = 0;
  int ptr_m = 0;
  bit pend = 0;
  int pend_id = 0;
  logic [DW-1:0] pend_data = '0;
  int gw;
  logic [N-1:0] obs_rv;
  logic [DW-1:0] obs_rd;

  mat_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MS; i++) dmem[i] <= DW'(i) * 32'h9E3779B1;
    end else if (mem_en) begin
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      else mem_rdata <= dmem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] we,
                      input logic [N-1:0] lk, input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    int w;
    logic [AW-1:0] wa;
    @(negedge clk);
    rst = r; req_valid = v; req_we = we; req_lock = lk; req_addr = a; req_wdata = d;
    #1;
    w = r ? -1 : pick(v, ptr_m);
    wa = (w >= 0) ? a[w*AW +: AW] : '0;
    check("ready", req_ready, (w >= 0) ? (N'(1) << w) : '0);
    check("mem_en", mem_en, w >= 0);
    check("mem_we", mem_we, (w >= 0) ? we[w] : 1'b0);
    check("mem_addr", mem_addr, wa);
    check("mem_wdata", mem_wdata, (w >= 0) ? d[w*DW +: DW] : '0);
    check("rsp_valid", rsp_valid, (!r && pend) ? (N'(1) << pend_id) : '0);
    check("rsp_rdata", rsp_rdata, (!r && pend) ? pend_data : '0);
    check("busy", busy, !r && (|v || pend));
    gw = w; obs_rv = rsp_valid; obs_rd = rsp_rdata;
    @(posedge clk);
    if (r) begin
      ptr_m = 0; pend = 0;
    end else begin
      pend = (w >= 0) && !we[w];
      if (w >= 0) begin
        pend_id = w;
        pend_data = shadow[wa];
        if (we[w]) shadow[wa] = d[w*DW +: DW];
        ptr_m = lk[w] ? w : (w + 1) % N;
      end
    end
  endtask

  initial begin
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    for (int i = 0; i < MS; i++) shadow[i] = DW'(i) * 32'h9E3779B1;
    rst = 1'b1; init_mem = 1'b1; mem_rdata = '0;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    step(1, 4'b1111, 4'b0000, 4'b0000, '0, '0);
    init_mem = 1'b0;
    step(1, 4'b0011, 4'b0000, 4'b0000, '0, '0);
    // fairness: two readers alternate
    a = '0; a[0 +: AW] = 5; a[AW +: AW] = 9;
    for (int k = 0; k < 6; k++) begin
      step(0, 4'b0011, 4'b0000, 4'b0000, a, '0);
      check("fair_grant", gw, k % 2);
      if (k > 0) check("fair_rsp", obs_rv, (k % 2) ? 4'b0001 : 4'b0010);
    end
    step(0, 4'b0000, 4'b0000, 4'b0000, a, '0);
    // single requester write then read of 3.5
    a = '0; a[AW +: AW] = 7; d = '0; d[DW +: DW] = 32'h40600000;
    step(0, 4'b0010, 4'b0010, 4'b0000, a, d);
    check("single_we", mem_we, 1'b1);
    step(0, 4'b0010, 4'b0000, 4'b0000, a, '0);
    step(0, 4'b0000, 4'b0000, 4'b0000, '0, '0);
    check("single_rv", obs_rv, 4'b0010);
    check("single_rd", obs_rd, 32'h40600000);
    // lock burst: requester 0 holds 4 grants against requester 1
    a = '0; a[0 +: AW] = 3; a[AW +: AW] = 4;
    for (int k = 0; k < 5; k++) begin
      step(0, 4'b0011, 4'b0000, (k < 3) ? 4'b0001 : 4'b0000, a, '0);
      check("lock_grant", gw, (k < 4) ? 0 : 1);
    end
    for (int k = 0; k < 10; k++) step(0, 4'b0000, 4'b0000, 4'b0000, '0, '0);
    // reset mid-read with ptr at 1
    step(0, 4'b0001, 4'b0000, 4'b0000, a, '0);
    step(1, 4'b0011, 4'b0000, 4'b0000, a, '0);
    check("rst_drop", obs_rv, 4'b0000);
    step(0, 4'b0010, 4'b0000, 4'b0000, a, '0);
    check("rst_first", gw, 1);
    step(1, 4'b0000, 4'b0000, 4'b0000, '0, '0);
    step(0, 4'b0011, 4'b0000, 4'b0000, a, '0);
    check("rst_first0", gw, 0);
    // wrap-around from ptr 3
    step(0, 4'b0100, 4'b0000, 4'b0000, a, '0);
    step(0, 4'b0101, 4'b0000, 4'b0000, a, '0);
    check("wrap0", gw, 0);
    step(0, 4'b0101, 4'b0000, 4'b0000, a, '0);
    check("wrap2", gw, 2);
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < N; i++) begin
        a[i*AW +: AW] = AW'($urandom_range(0, 15));
        d[i*DW +: DW] = $urandom;
      end
      step(($urandom_range(0, 39) == 0), N'($urandom), N'($urandom),
           N'($urandom) & N'($urandom), a, d);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
